// File: rtl/tdm_frame_sequencer.sv
// tdm_frame_sequencer: frames one tx/rx word per f0 strobe on the c4-timed serial TDM link to the DT line
module tdm_frame_sequencer #(
  parameter int   FRAME_BITS  = 32,
  parameter int   C4_PER_BIT  = 2,
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_LEVEL  = 1'b1
) (
  input  logic                  clk50,
  input  logic                  reset_n,
  input  logic                  f0,
  input  logic                  c4,
  input  logic                  select,
  input  logic                  data_from_dt,
  input  logic [FRAME_BITS-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  data_to_dt,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  cpu_int,
  input  logic                  cpu_ack,
  output logic                  tx_underrun,
  output logic                  rx_overrun,
  output logic                  frame_err
);
  localparam int BW = $clog2(FRAME_BITS);
  localparam int PW = $clog2(C4_PER_BIT + 1);
  typedef enum logic [1:0] {IDLE, WAIT_C4, SHIFT, DONE} state_t;
  state_t state, state_nxt;
  logic [SYNC_STAGES-1:0] f0_sync, c4_sync, rxd_sync;
  logic f0_prev, c4_prev, f0_fall, c4_rise, rxd;
  logic [FRAME_BITS-1:0] slot, tx_shift, rx_shift, word;
  logic slot_full, load, sample, step, err, fin, last_bit;
  logic [BW-1:0] bit_cnt;
  logic [PW-1:0] phase;
  assign f0_fall  = f0_prev & ~f0_sync[SYNC_STAGES-1];
  assign c4_rise  = c4_sync[SYNC_STAGES-1] & ~c4_prev;
  assign rxd      = rxd_sync[SYNC_STAGES-1];
  assign tx_ready = ~slot_full;
  assign word     = slot_full ? slot : {FRAME_BITS{IDLE_LEVEL}};
  assign last_bit = bit_cnt == BW'(FRAME_BITS - 1);
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      f0_sync  <= '0;
      c4_sync  <= '0;
      rxd_sync <= '0;
      f0_prev  <= 1'b0;
      c4_prev  <= 1'b0;
    end else begin
      f0_sync  <= {f0_sync[SYNC_STAGES-2:0], f0};
      c4_sync  <= {c4_sync[SYNC_STAGES-2:0], c4};
      rxd_sync <= {rxd_sync[SYNC_STAGES-2:0], data_from_dt};
      f0_prev  <= f0_sync[SYNC_STAGES-1];
      c4_prev  <= c4_sync[SYNC_STAGES-1];
    end
  end
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    sample    = 1'b0;
    step      = 1'b0;
    err       = 1'b0;
    fin       = 1'b0;
    if (!select) state_nxt = IDLE;
    else begin
      case (state)
        IDLE: state_nxt = f0_fall ? WAIT_C4 : IDLE;
        WAIT_C4: begin
          err       = f0_fall;
          load      = c4_rise & ~f0_fall;
          state_nxt = load ? SHIFT : WAIT_C4;
        end
        SHIFT: begin
          err       = f0_fall;
          sample    = c4_rise & ~f0_fall & (phase == PW'(C4_PER_BIT - 1));
          step      = c4_rise & ~f0_fall & ~sample;
          state_nxt = err ? WAIT_C4 : (sample & last_bit) ? DONE : SHIFT;
        end
        default: begin
          fin       = 1'b1;
          state_nxt = IDLE;
        end
      endcase
    end
  end
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      slot        <= '0;
      slot_full   <= 1'b0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      rx_data     <= '0;
      cpu_int     <= 1'b0;
      data_to_dt  <= IDLE_LEVEL;
      bit_cnt     <= '0;
      phase       <= '0;
      tx_underrun <= 1'b0;
      rx_overrun  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      tx_underrun <= load & ~slot_full;
      rx_overrun  <= fin & cpu_int;
      frame_err   <= err;
      if (load & slot_full) slot_full <= 1'b0;
      else if (tx_valid & ~slot_full) begin
        slot      <= tx_data;
        slot_full <= 1'b1;
      end
      if (load) begin
        tx_shift <= {word[FRAME_BITS-2:0], IDLE_LEVEL};
        rx_shift <= '0;
        bit_cnt  <= '0;
        phase    <= PW'(C4_PER_BIT > 1);
      end else if (sample) begin
        tx_shift <= {tx_shift[FRAME_BITS-2:0], IDLE_LEVEL};
        rx_shift <= {rx_shift[FRAME_BITS-2:0], rxd};
        bit_cnt  <= bit_cnt + 1'b1;
        phase    <= '0;
      end else if (step) phase <= phase + 1'b1;
      data_to_dt <= load ? word[FRAME_BITS-1] :
                    (sample & ~last_bit) ? tx_shift[FRAME_BITS-1] :
                    (state_nxt == SHIFT || state_nxt == DONE) ? data_to_dt : IDLE_LEVEL;
      if (fin) begin
        rx_data <= rx_shift;
        cpu_int <= 1'b1;
      end else if (cpu_ack) cpu_int <= 1'b0;
    end
  end
endmodule

// File: doc/tdm_frame_sequencer.md
Name: tdm_frame_sequencer

Overview:
- Sequences the serial TDM link between the DT line and the STM host in the clk50 domain.
- Detects the f0 frame strobe and derives bit timing from the c4 line clock.
- Shifts one FRAME_BITS-wide word out on data_to_dt and captures one word from data_from_dt per frame.
- Presents received words to the host with cpu_int and accepts transmit words over a valid/ready handshake.

Parameters:
- FRAME_BITS, 32, bits per frame and width of the tx/rx words.
- C4_PER_BIT, 2, c4 rising edges per bit cell.
- SYNC_STAGES, 2, synchronizer flops on f0, c4 and data_from_dt.
- IDLE_LEVEL, 1'b1, level driven on data_to_dt when not shifting or on underrun.

Ports:
- clk50  input  1  system clock, 50 MHz.
- reset_n  input  1  asynchronous active-low reset.
- f0  input  1  frame strobe, asynchronous; frame starts on its falling edge.
- c4  input  1  line clock, asynchronous, below clk50/4.
- select  input  1  link enable; low forces IDLE.
- data_from_dt  input  1  serial receive data, asynchronous.
- tx_data  input  FRAME_BITS  host word to transmit.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  pending-word slot empty.
- data_to_dt  output  1  serial transmit data, MSB first.
- rx_data  output  FRAME_BITS  last complete received word.
- cpu_int  output  1  received word available, level.
- cpu_ack  input  1  host acknowledge, one-cycle pulse.
- tx_underrun  output  1  one-cycle pulse: a frame started with no pending word.
- rx_overrun  output  1  one-cycle pulse: a word completed while cpu_int was high.
- frame_err  output  1  one-cycle pulse: f0 fell mid-frame.

Behaviour:
- Reset values: data_to_dt=IDLE_LEVEL, tx_ready=1, rx_data=0, cpu_int=0, all pulses=0, state=IDLE, counters=0, pending slot empty.
- Synchronization:
  - f0, c4 and data_from_dt each pass through SYNC_STAGES flops.
  - f0_fall and c4_rise are single-cycle pulses from the synchronized signal and its previous value.
- TX handshake:
  - tx_ready = pending slot empty.
  - On tx_valid && tx_ready, tx_data is latched into the slot; tx_ready drops the next cycle.
  - tx_valid while tx_ready=0 is ignored.
- State machine IDLE / WAIT_C4 / SHIFT / DONE:
  - IDLE: data_to_dt=IDLE_LEVEL. On f0_fall && select, go to WAIT_C4.
  - WAIT_C4, first c4_rise:
    - If the slot is full: load the shift register from the slot, empty it, and raise tx_ready the next cycle.
    - If the slot is empty: load all IDLE_LEVEL and pulse tx_underrun.
    - Drive bit FRAME_BITS-1 on data_to_dt; set bit_cnt=0, phase=1; go to SHIFT.
  - SHIFT, each c4_rise:
    - If phase==C4_PER_BIT-1: sample synced data_from_dt into rx_shift LSB (shift left), increment bit_cnt, phase=0.
    - If bit_cnt was FRAME_BITS-1, go to DONE; otherwise drive the next tx bit on the same cycle.
    - Else phase increments.
  - DONE (one cycle):
    - rx_data <= rx_shift.
    - If cpu_int is already 1, pulse rx_overrun; rx_data is still overwritten.
    - Set cpu_int=1, data_to_dt=IDLE_LEVEL, go to IDLE.
- Bit timing: one bit = C4_PER_BIT c4 cycles. Data is sampled on the last c4 rise of each cell.
- cpu_int:
  - Cleared on cpu_ack.
  - If DONE and cpu_ack occur in the same cycle, DONE wins and cpu_int stays 1.
- Errors and aborts:
  - f0_fall in WAIT_C4 or SHIFT: pulse frame_err, discard the partial rx word, go straight to WAIT_C4. This is a resync, not a return to IDLE.
  - A word already moved to the shift register is lost; no retransmit.
  - select low in any state: go to IDLE next cycle, data_to_dt=IDLE_LEVEL, no pulses. The pending slot and rx_data are kept.
- Async reset mid-frame returns everything to reset values immediately.
- Latency: last sampling c4_rise to cpu_int high is 2 clk50 cycles (capture in SHIFT, DONE, register). Add SYNC_STAGES+1 cycles to refer to the pin.

Test Plan:
- Preload tx 0xA5C3_0F81, f0 fall, 64 c4 cycles with data_from_dt pattern 0x1234_5678 → data_to_dt serializes 0xA5C3_0F81 MSB first, rx_data=0x1234_5678, cpu_int=1, tx_ready=1 after load.
- Frame with no tx word → one tx_underrun pulse, data_to_dt stays 1 for all 32 bits.
- Two frames without cpu_ack, rx 0x0000_0001 then 0xFFFF_0000 → rx_overrun pulses once at second DONE, rx_data=0xFFFF_0000; cpu_ack clears cpu_int.
- f0 falls again after bit 10 → frame_err pulse, new frame completes cleanly with a new 32-bit word, no cpu_int from the aborted frame.
- select dropped at bit 5 → data_to_dt=1 next cycle, no cpu_int; pending tx word still present (tx_ready=0).
- reset_n low mid-SHIFT → all outputs at reset values asynchronously; next f0 fall runs a normal frame.
